uart_tx_fifo: RTL

Buffered UART transmitter peripheral on the system bus, in the 0x50000010–0x5000001F window. It accepts bytes from bus writes into a FIFO and serialises them 8N1 on the TX pin at a fixed baud rate. Bus stalls through `o_ready` occur only when the FIFO is full, so the CPU no longer blocks for a full character time per byte.

---
 rtl/uart_tx_fifo_if.sv | 20 ++
 rtl/uart_tx_fifo.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_if.sv
// Bus-side handshake for uart_tx_fifo: select, direction, offset, data and the
// registered completion flag. The master drives the request, the slave answers.
interface uart_tx_fifo_if;
  logic        i_enable;
  logic        i_rw;
  logic [3:0]  i_address;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_ready;

  modport master (
    output i_enable, i_rw, i_address, i_wdata,
    input  o_rdata, o_ready
  );

  modport slave (
    input  i_enable, i_rw, i_address, i_wdata,
    output o_rdata, o_ready
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: bus writes fill a FIFO, a shifter drains it as 8N1
// frames. Define UART_TX_FIFO_PARITY_EN to insert an even-parity bit (8E1).
module uart_tx_fifo #(
  parameter int CLOCK_RATE = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic          i_clock,
  input  logic          i_reset_n,
  uart_tx_fifo_if.slave bus,
  output logic          o_tx,
  output logic          o_busy
);
  localparam int BIT_CYCLES = CLOCK_RATE / BAUD_RATE;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int CNT_W      = $clog2(BIT_CYCLES);

  if (BIT_CYCLES < 2) begin : g_bad_baud
    $error("uart_tx_fifo: CLOCK_RATE / BAUD_RATE must be at least 2");
  end

  typedef logic [DEPTH_LOG2:0] ptr_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_FIFO_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [7:0]       mem [DEPTH];
  ptr_t             wptr, rptr, count;
  logic             empty, full, push, pop;
  logic             is_data, pending, done;
  logic [31:0]      status;
  logic             unused_wdata;

  state_t           state, state_next;
  logic [CNT_W-1:0] cyc_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             bit_done, tx_next;
`ifdef UART_TX_FIFO_PARITY_EN
  logic             parity_bit;
`endif

  // The pointer MSB separates a full buffer from an empty one.
  assign count = wptr - rptr;
  assign empty = (count == '0);
  assign full  = (count == ptr_t'(DEPTH));

  assign is_data      = (bus.i_address == 4'h0);
  assign pending      = bus.i_enable && !bus.o_ready;
  assign push         = pending && bus.i_rw && is_data && !full;
  assign done         = pending && !(bus.i_rw && is_data && full);
  assign status       = {22'b0, 8'(count), full, empty};
  assign unused_wdata = ^bus.i_wdata[31:8];

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      bus.o_ready <= 1'b0;
      bus.o_rdata <= '0;
      wptr        <= '0;
      rptr        <= '0;
    end else begin
      // Ready holds until the select drops, so one assertion is one access.
      bus.o_ready <= bus.i_enable && (bus.o_ready || done);
      if (done && !bus.i_rw) bus.o_rdata <= status;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone say which entries are valid.
  always_ff @(posedge i_clock) begin
    if (push) mem[wptr[DEPTH_LOG2-1:0]] <= bus.i_wdata[7:0];
  end

  // Popping straight out of STOP is what makes back-to-back frames gapless.
  assign bit_done = (cyc_cnt == CNT_W'(BIT_CYCLES - 1));
  assign pop      = !empty && (state == S_IDLE || (state == S_STOP && bit_done));
  assign o_busy   = !empty || (state != S_IDLE);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= S_IDLE;
      cyc_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
`ifdef UART_TX_FIFO_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (state == S_IDLE || bit_done) cyc_cnt <= '0;
      else                             cyc_cnt <= cyc_cnt + 1'b1;
      if (state == S_DATA && bit_done) bit_idx <= bit_idx + 1'b1;
      else if (state != S_DATA)        bit_idx <= '0;
      if (pop) begin
        shreg <= mem[rptr[DEPTH_LOG2-1:0]];
`ifdef UART_TX_FIFO_PARITY_EN
        parity_bit <= ^mem[rptr[DEPTH_LOG2-1:0]];
`endif
      end else if (state == S_DATA && bit_done) begin
        shreg <= shreg >> 1;
      end
    end
  end

  // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (!empty) state_next = S_START;
      S_START:  if (bit_done) state_next = S_DATA;
`ifdef UART_TX_FIFO_PARITY_EN
      S_DATA:   if (bit_done && bit_idx == 3'd7) state_next = S_PARITY;
      S_PARITY: if (bit_done) state_next = S_STOP;
`else
      S_DATA:   if (bit_done && bit_idx == 3'd7) state_next = S_STOP;
`endif
      S_STOP:   if (bit_done) state_next = empty ? S_IDLE : S_START;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    tx_next = 1'b1;
    case (state)
      S_START:  tx_next = 1'b0;
      S_DATA:   tx_next = shreg[0];
`ifdef UART_TX_FIFO_PARITY_EN
      S_PARITY: tx_next = parity_bit;
`endif
      default:  tx_next = 1'b1;
    endcase
  end

  // The line is retimed through a flop, so it trails the state by one clock.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) o_tx <= 1'b1;
    else            o_tx <= tx_next;
  end
endmodule
